// File: rtl/debug_tx_pkg.sv
// Shared types and constants for the debug UART transmit sequencer.
package debug_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam int         MAX_REQ = 16;
  localparam int         SRC_W   = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set req bit at or after ptr, modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0] cand [NUM_REQ];

  // cand[k] is the requester index k positions after ptr, wrapped by compare.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : IDX_W'(sum);
  end

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        winner  = cand[i];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_tx_sequencer.sv
// Round-robin word sequencer feeding one UART TX byte-by-byte, LSB byte first.
// Define DEBUG_TX_HEADER_EN to prefix each word with a {HDR_TAG, src_id} header byte.
module debug_tx_sequencer
  import debug_tx_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WORD_BYTES = 4
) (
  input  logic                            CLK_100MHZ,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*8*WORD_BYTES-1:0] word_in,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            tx_start,
  output logic [7:0]                      tx_data,
  input  logic                            tx_done_tick,
  output logic                            word_done,
  output logic                            busy
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = ($clog2(WORD_BYTES + 1) < 1) ? 1 : $clog2(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
`ifdef DEBUG_TX_HEADER_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);
`endif

  tx_state_t          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [WORD_W-1:0]  word_reg, word_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               tx_start_reg, tx_start_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic               word_done_reg, word_done_next;
  logic               busy_reg, busy_next;
`ifdef DEBUG_TX_HEADER_EN
  logic [SRC_W-1:0]   src_reg, src_next;
`endif

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               load_byte;
  logic [CNT_W-1:0]   data_idx;
  logic [7:0]         byte_sel;
  logic [WORD_W-1:0]  req_word [NUM_REQ];

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign req_word[gi] = word_in[gi*WORD_W +: WORD_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      word_reg      <= '0;
      ack_reg       <= '0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
      word_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef DEBUG_TX_HEADER_EN
      src_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      word_reg      <= word_next;
      ack_reg       <= ack_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
      word_done_reg <= word_done_next;
      busy_reg      <= busy_next;
`ifdef DEBUG_TX_HEADER_EN
      src_reg       <= src_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ptr_next       = ptr_reg;
    word_next      = word_reg;
    ack_next       = '0;
    tx_start_next  = 1'b0;
    tx_data_next   = tx_data_reg;
    word_done_next = 1'b0;
    load_byte      = 1'b0;
    data_idx       = '0;
    byte_sel       = '0;
`ifdef DEBUG_TX_HEADER_EN
    src_next       = src_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next       = SEND;
          ack_next[winner] = 1'b1;
          ptr_next         = (winner == LAST_IDX) ? '0 : winner + 1'b1;
          cnt_next         = '0;
          word_next        = req_word[winner];
          load_byte        = 1'b1;
`ifdef DEBUG_TX_HEADER_EN
          src_next         = SRC_W'(winner);
`endif
        end
      end
      SEND: state_next = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          if (cnt_reg == LAST_CNT) begin
            state_next     = DONE;
            word_done_next = 1'b1;
          end else begin
            state_next = SEND;
            cnt_next   = cnt_reg + 1'b1;
            load_byte  = 1'b1;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Byte for the upcoming SEND cycle is chosen from the next-state word so the grant cycle already drives byte 0.
`ifdef DEBUG_TX_HEADER_EN
    data_idx = cnt_next - 1'b1;
`else
    data_idx = cnt_next;
`endif
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (data_idx == CNT_W'(b)) begin
        byte_sel = word_next[b*8 +: 8];
      end
    end
`ifdef DEBUG_TX_HEADER_EN
    if (cnt_next == '0) begin
      byte_sel = {HDR_TAG, src_next};
    end
`endif

    if (load_byte) begin
      tx_start_next = 1'b1;
      tx_data_next  = byte_sel;
    end
    busy_next = (state_next != IDLE);
  end

  assign ack       = ack_reg;
  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;
  assign word_done = word_done_reg;
  assign busy      = busy_reg;

endmodule

// File: doc/debug_tx_sequencer.md
Name: debug_tx_sequencer

Overview:
- Shares the single UART transmitter of the debug unit between N word-producing requesters (register dump, memory dump, PC/status reporter).
- Arbitrates round-robin, latches the winner's word and serializes it into bytes, LSB byte first.
- Handshakes each byte with the UART TX (tx_start / tx_done_tick); the TX is paced by the 16x baud-tick generator.

Parameters:
- NUM_REQ, 2, number of requesters (1..16).
- WORD_BYTES, 4, bytes per word (word width = 8*WORD_BYTES).
- CNT_W, $clog2(WORD_BYTES+1) (minimum 1), byte counter width; derived, not overridden.

Ports:
- CLK_100MHZ  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester "word valid"; held until acked.
- word_in  in  NUM_REQ*8*WORD_BYTES  flattened words; requester i at bits [i*8*WORD_BYTES +: 8*WORD_BYTES].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: word i latched.
- tx_start  out  1  one-cycle pulse: UART TX loads tx_data.
- tx_data  out  8  byte to transmit; valid while tx_start=1.
- tx_done_tick  in  1  one-cycle pulse from UART TX: stop bit finished.
- word_done  out  1  one-cycle pulse after the last byte of a word completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: ack=0, tx_start=0, tx_data=0, word_done=0, busy=0, state=IDLE, byte_cnt=0, rr pointer=0 (requester 0 has top priority).
- Reset mid-word: the word is abandoned immediately. No ack, no word_done. The partially sent word is not resumed.
- States:
  - IDLE: if any req bit is set, pick the first set bit at or after the rr pointer (modulo NUM_REQ). Next cycle: latch word, state=SEND, ack[winner]=1 for that one cycle, rr pointer=winner+1 mod NUM_REQ, byte_cnt=0.
  - SEND: lasts exactly 1 cycle. tx_start=1 and tx_data=byte[byte_cnt] of the latched word, all registered outputs. Next state is WAIT.
  - WAIT: hold until tx_done_tick=1.
    - If byte_cnt==WORD_BYTES-1: go to DONE.
    - Otherwise: byte_cnt+1, go to SEND.
  - DONE: 1 cycle. word_done=1, then IDLE.
- Latency: req sampled high at edge k gives ack and SEND state at k+1, and tx_start visible in cycle k+1. After tx_done_tick at edge m, the next tx_start is at m+1. After the last tx_done_tick at m, word_done is at m+1 and req is sampled again at m+2.
- tx_done_tick outside WAIT is ignored (no counting, no state change).
- A requester that keeps req high after ack is treated as having another word ready. With other requesters active it is not re-served before them.
- word_in of the winner is sampled only on the grant edge. Later changes do not affect the word in flight.
- req bits outside IDLE are ignored (not latched).
- Counter and pointer wrap via explicit compare, never by natural overflow; NUM_REQ need not be a power of 2.

Optional Feature:
- Macro DEBUG_TX_HEADER_EN.
- Defined: each word is preceded by a header byte {4'hA, src_id[3:0]}, sent in its own SEND/WAIT pair before byte 0. Words are WORD_BYTES+1 bytes on the line, and byte_cnt spans 0..WORD_BYTES.
- Undefined: exactly WORD_BYTES bytes per word, with no header logic synthesized.

Decomposition:
- Package debug_tx_pkg holds:
  - state encoding (IDLE, SEND, WAIT, DONE; 2 bits);
  - HDR_TAG = 4'hA;
  - MAX_REQ = 16.
- Sub-module rr_arbiter(NUM_REQ): combinational grant from req and pointer, returning winner index and any_req. The pointer register stays in the top module.

Test Plan:
- Single word: req=2'b01, word_in[31:0]=32'hDEADBEEF; the TX model returns tx_done_tick 5 cycles after each tx_start. Expect: ack=01 one cycle, tx_data sequence EF,BE,AD,DE, exactly 4 tx_start pulses, one word_done, busy low afterwards.
- Contention: req=2'b11 held continuously, words 32'h11111111 / 32'h22222222. Expect grant order 0,1,0,1 over 4 words; no requester is served twice in a row.
- Spurious tick: pulse tx_done_tick in IDLE and on the SEND cycle. Expect no state change and no extra bytes; the word still produces exactly 4 bytes.
- Reset mid-word: assert reset in WAIT after the 2nd byte. Expect all outputs 0 the next cycle, no word_done. After release, req=2'b10 is granted to requester 1 (pointer 0 scans from 0 and only bit 1 is set).
- Word change after ack: change word_in of the winner to 32'h0 the cycle after ack. Expect the original bytes transmitted.
- DEBUG_TX_HEADER_EN defined, NUM_REQ=2, requester 1 sends 32'h01020304. Expect tx_data sequence A1,04,03,02,01 and one word_done.
